// File: rtl/df_ifmaps_dma_req_gen.sv
// Expands one ifmaps tile (c outer, y inner) into row-burst DMA requests {addr,len,last}.
// First request one cycle after start; payload held while valid & !ready; done one cycle after last accept.
module df_ifmaps_dma_req_gen #(
   parameter int ADDR_W = 32,
   parameter int ETT_W  = 24,
   parameter int YS_W   = 12,
   parameter int CS_W   = 24,
   parameter int CL_W   = 12
) (
   input  logic              i_clk,
   input  logic              i_rstn,
   input  logic              i_start,
   input  logic              i_abort,
   input  logic [ADDR_W-1:0] i_base,
   input  logic [ETT_W-1:0]  i_ett,
   input  logic [YS_W-1:0]   i_y_step,
   input  logic [YS_W-1:0]   i_y_lim,
   input  logic [CS_W-1:0]   i_c_step,
   input  logic [CL_W-1:0]   i_c_lim,
   output logic              o_req_valid,
   input  logic              i_req_ready,
   output logic [ADDR_W-1:0] o_req_addr,
   output logic [ETT_W-1:0]  o_req_len,
   output logic              o_req_last,
   output logic              o_busy,
   output logic              o_done,
   output logic              o_cfg_err
);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t                 r_state, w_state_nxt;
   logic [ADDR_W-1:0]      r_base;
   logic [ETT_W-1:0]       r_ett;
   logic [YS_W-1:0]        r_y_step, r_y_lim;
   logic [CS_W-1:0]        r_c_step;
   logic [CL_W-1:0]        r_c_lim, r_c_idx;
   logic [YS_W:0]          r_y_off;
   logic [CS_W+CL_W-1:0]   r_c_off;
   logic                   r_cfg_err;

   logic                   w_latch, w_load, w_err_nxt, w_acc, w_degen;
   logic                   w_y_end, w_last, w_run;
   logic [YS_W:0]          w_y_next;
   logic [ADDR_W-1:0]      w_addr;

   assign w_degen  = (i_y_lim == '0) || (i_c_lim == '0) || (i_y_step == '0) || (i_ett == '0);
   // Extra top bit keeps y_off+y_step from wrapping back below y_lim.
   assign w_y_next = r_y_off + {1'b0, r_y_step};
   assign w_y_end  = (w_y_next >= {1'b0, r_y_lim});
   assign w_last   = w_y_end && (r_c_idx == (r_c_lim - CL_W'(1)));
   assign w_addr   = r_base + ADDR_W'(r_c_off) + ADDR_W'(r_y_off);
   assign w_run    = (r_state == S_RUN);

   always_comb begin
      w_state_nxt = r_state;
      w_latch     = 1'b0;
      w_load      = 1'b0;
      w_err_nxt   = 1'b0;
      w_acc       = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (i_start && !i_abort) begin
               w_latch = 1'b1;
               if (w_degen) begin
                  w_err_nxt = 1'b1;
               end else begin
                  w_load      = 1'b1;
                  w_state_nxt = S_RUN;
               end
            end
         end
         S_RUN: begin
            if (i_abort) begin
               w_state_nxt = S_IDLE;
            end else if (i_req_ready) begin
               w_acc = 1'b1;
               if (w_last) w_state_nxt = S_DONE;
            end
         end
         S_DONE:  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         r_base    <= '0;
         r_ett     <= '0;
         r_y_step  <= '0;
         r_y_lim   <= '0;
         r_c_step  <= '0;
         r_c_lim   <= '0;
         r_c_idx   <= '0;
         r_y_off   <= '0;
         r_c_off   <= '0;
         r_cfg_err <= 1'b0;
      end else begin
         r_cfg_err <= w_err_nxt;
         if (w_latch) begin
            r_base   <= i_base;
            r_ett    <= i_ett;
            r_y_step <= i_y_step;
            r_y_lim  <= i_y_lim;
            r_c_step <= i_c_step;
            r_c_lim  <= i_c_lim;
         end
         if (w_load) begin
            r_c_idx <= '0;
            r_y_off <= '0;
            r_c_off <= '0;
         end else if (w_acc) begin
            if (w_y_end) begin
               r_y_off <= '0;
               r_c_idx <= r_c_idx + CL_W'(1);
               r_c_off <= r_c_off + {{CL_W{1'b0}}, r_c_step};
            end else begin
               r_y_off <= w_y_next;
            end
         end
      end
   end

   assign o_req_valid = w_run;
   assign o_req_addr  = w_run ? w_addr : '0;
   assign o_req_len   = w_run ? r_ett : '0;
   assign o_req_last  = w_run && w_last;
   assign o_busy      = (r_state == S_RUN) || (r_state == S_DONE);
   assign o_done      = (r_state == S_DONE) || r_cfg_err;
   assign o_cfg_err   = r_cfg_err;

endmodule
